// File: rtl/formatted_recv_if.sv
// Host-side serial line plus decoded command outputs of the ASCII debug receiver.
interface formatted_recv_if;
  logic        uart_rxd;
  logic [11:0] addr;
  logic [7:0]  data;
  logic        cmd_valid;
  logic        cmd_err;
  logic        rx_busy;

  // Host side: drives the serial line and observes decoded commands.
  modport master (
    output uart_rxd,
    input  addr, data, cmd_valid, cmd_err, rx_busy
  );

  // Receiver side.
  modport slave (
    input  uart_rxd,
    output addr, data, cmd_valid, cmd_err, rx_busy
  );
endinterface

// File: rtl/formatted_recv.sv
// UART receiver (8 data bits, optional even parity, 1 stop) feeding a parser
// for "AAA: DD\n" write commands.
module formatted_recv #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter bit          PARITY_EN = 1'b1
) (
  input logic             CLK_50M,
  input logic             rst_n,
  formatted_recv_if.slave bus
);

  localparam int unsigned BIT_TICKS = CLK_FREQ / BAUD;
  localparam int unsigned HALF      = BIT_TICKS / 2;
  localparam int unsigned TW        = $clog2(BIT_TICKS + 1);
  localparam logic [7:0]  CH_LF     = 8'h0A;
  localparam logic [7:0]  CH_CR     = 8'h0D;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [3:0] {P_A0, P_A1, P_A2, P_COL, P_SP, P_D0, P_D1, P_LF, P_ERR} p_state_t;

  logic           r_sync1, r_sync2, r_sync_d;
  rx_state_t      r_rx_state, w_rx_next;
  logic [TW-1:0]  r_tick;
  logic [2:0]     r_bitcnt;
  logic [7:0]     r_shift;
  logic           r_bad;
  logic           w_fall, w_half, w_full, w_byte_stb, w_byte_bad;

  p_state_t       r_p_state, w_p_next;
  logic [11:0]    r_addr_sh, w_addr_sh_n, r_addr, w_addr_n;
  logic [7:0]     r_data_sh, w_data_sh_n, r_data, w_data_n;
  logic           r_cmd_valid, w_valid_n, r_cmd_err, w_err_n;
  logic [4:0]     w_hex;
  logic           w_ok;

  assign w_fall     = r_sync_d & ~r_sync2;
  assign w_half     = (r_tick == TW'(HALF - 1));
  assign w_full     = (r_tick == TW'(BIT_TICKS - 1));
  assign w_byte_bad = r_bad | ~r_sync2;

  // Two-flop synchronizer plus previous-value flop for edge detection.
  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync1  <= bus.uart_rxd;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  // RX state register.
  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) r_rx_state <= RX_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  // RX next-state and byte strobe; stop sample returns straight to IDLE.
  always_comb begin
    w_rx_next  = r_rx_state;
    w_byte_stb = 1'b0;
    case (r_rx_state)
      RX_IDLE:   if (w_fall) w_rx_next = RX_START;
      RX_START:  if (w_half) w_rx_next = r_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_full && r_bitcnt == 3'd7) w_rx_next = PARITY_EN ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_full) w_rx_next = RX_STOP;
      RX_STOP:   if (w_full) begin
                   w_rx_next  = RX_IDLE;
                   w_byte_stb = 1'b1;
                 end
      default:   w_rx_next = RX_IDLE;
    endcase
  end

  // Bit timing, shift register and parity/framing status.
  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_tick   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_bad    <= 1'b0;
    end else begin
      if (r_rx_state == RX_IDLE || (r_rx_state == RX_START && w_half) || w_full)
        r_tick <= '0;
      else
        r_tick <= r_tick + 1'b1;
      if (r_rx_state == RX_IDLE) begin
        r_bitcnt <= '0;
        r_bad    <= 1'b0;
      end
      if (r_rx_state == RX_DATA && w_full) begin
        r_bitcnt <= r_bitcnt + 1'b1;
        r_shift  <= {r_sync2, r_shift[7:1]};
      end
      if (r_rx_state == RX_PARITY && w_full)
        r_bad <= r_bad | (^r_shift ^ r_sync2);
    end
  end

  // Hex digit decode: {valid, nibble}.
  always_comb begin
    w_hex = '0;
    if (r_shift >= 8'h30 && r_shift <= 8'h39)      w_hex = {1'b1, r_shift[3:0]};
    else if (r_shift >= 8'h41 && r_shift <= 8'h46) w_hex = {1'b1, 4'(r_shift - 8'h37)};
    else if (r_shift >= 8'h61 && r_shift <= 8'h66) w_hex = {1'b1, 4'(r_shift - 8'h57)};
  end

  // Parser state and output registers.
  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_p_state   <= P_A0;
      r_addr_sh   <= '0;
      r_data_sh   <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_p_state   <= w_p_next;
      r_addr_sh   <= w_addr_sh_n;
      r_data_sh   <= w_data_sh_n;
      r_addr      <= w_addr_n;
      r_data      <= w_data_n;
      r_cmd_valid <= w_valid_n;
      r_cmd_err   <= w_err_n;
    end
  end

  // Parser next-state: CR always skipped, LF in P_A0 ignored, errors park in P_ERR until LF.
  always_comb begin
    w_p_next    = r_p_state;
    w_addr_sh_n = r_addr_sh;
    w_data_sh_n = r_data_sh;
    w_addr_n    = r_addr;
    w_data_n    = r_data;
    w_valid_n   = 1'b0;
    w_err_n     = 1'b0;
    w_ok        = 1'b0;
    if (w_byte_stb) begin
      if (r_p_state == P_ERR) begin
        if (r_shift == CH_LF) w_p_next = P_A0;
      end else if (!w_byte_bad && r_shift == CH_CR) begin
        w_ok = 1'b1;
      end else if (!w_byte_bad && r_p_state == P_A0 && r_shift == CH_LF) begin
        w_ok = 1'b1;
      end else begin
        if (!w_byte_bad) begin
          case (r_p_state)
            P_A0, P_A1, P_A2: if (w_hex[4]) begin
              w_ok        = 1'b1;
              w_addr_sh_n = {r_addr_sh[7:0], w_hex[3:0]};
              w_p_next    = (r_p_state == P_A0) ? P_A1 : (r_p_state == P_A1) ? P_A2 : P_COL;
            end
            P_COL: if (r_shift == 8'h3A) begin w_ok = 1'b1; w_p_next = P_SP; end
            P_SP:  if (r_shift == 8'h20) begin w_ok = 1'b1; w_p_next = P_D0; end
            P_D0, P_D1: if (w_hex[4]) begin
              w_ok        = 1'b1;
              w_data_sh_n = {r_data_sh[3:0], w_hex[3:0]};
              w_p_next    = (r_p_state == P_D0) ? P_D1 : P_LF;
            end
            P_LF: if (r_shift == CH_LF) begin
              w_ok      = 1'b1;
              w_addr_n  = r_addr_sh;
              w_data_n  = r_data_sh;
              w_valid_n = 1'b1;
              w_p_next  = P_A0;
            end
            default: w_ok = 1'b0;
          endcase
        end
        if (!w_ok) begin
          w_err_n  = 1'b1;
          w_p_next = (r_shift == CH_LF) ? P_A0 : P_ERR;
        end
      end
    end
  end

  assign bus.addr      = r_addr;
  assign bus.data      = r_data;
  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_err   = r_cmd_err;
  assign bus.rx_busy   = (r_rx_state != RX_IDLE);

endmodule

// File: tb/tb_formatted_recv.sv
// Directed bench for formatted_recv at a scaled clock (16 clocks per bit).
module tb_formatted_recv;
  localparam int unsigned CLK_FREQ = 153_600;
  localparam int unsigned BAUD     = 9600;
  localparam int BIT = CLK_FREQ / BAUD;

  logic CLK_50M = 1'b0;
  logic rst_n   = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   n_valid = 0;
  int   n_err   = 0;
  int   n_both  = 0;

  formatted_recv_if bus ();

  formatted_recv #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_EN(1'b1)) dut (
    .CLK_50M (CLK_50M),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  always #5 CLK_50M = ~CLK_50M;

  always @(negedge CLK_50M) begin
    if (rst_n) begin
      if (bus.cmd_valid === 1'b1) n_valid++;
      if (bus.cmd_err === 1'b1) n_err++;
      if (bus.cmd_valid === 1'b1 && bus.cmd_err === 1'b1) n_both++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit flip, input int stop_clk);
    @(negedge CLK_50M) bus.uart_rxd = 1'b0;
    repeat (BIT) @(negedge CLK_50M);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rxd = b[i];
      repeat (BIT) @(negedge CLK_50M);
    end
    bus.uart_rxd = (^b) ^ flip;
    repeat (BIT) @(negedge CLK_50M);
    bus.uart_rxd = 1'b1;
    repeat (stop_clk - 1) @(negedge CLK_50M);
  endtask

  task automatic send_str(input string s, input int flip_idx, input int stop_clk);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], i == flip_idx, stop_clk);
    repeat (2 * BIT) @(negedge CLK_50M);
  endtask

  task automatic test_reset;
    if (bus.addr !== 12'h000) begin errors++; $display("FAIL reset_addr got %h want 000", bus.addr); end
    checks++;
    if (bus.data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.data); end
    checks++;
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.cmd_valid); end
    checks++;
    if (bus.cmd_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.cmd_err); end
    checks++;
    if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.rx_busy); end
    checks++;
  endtask

  task automatic test_line(input string name, input string s, input int flip_idx, input int stop_clk,
                           input int exp_v, input int exp_e, input logic [11:0] exp_a, input logic [7:0] exp_d);
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_str(s, flip_idx, stop_clk);
    if (n_valid - v0 !== exp_v) begin errors++; $display("FAIL %s_valid_count got %0d want %0d", name, n_valid - v0, exp_v); end
    checks++;
    if (n_err - e0 !== exp_e) begin errors++; $display("FAIL %s_err_count got %0d want %0d", name, n_err - e0, exp_e); end
    checks++;
    if (bus.addr !== exp_a) begin errors++; $display("FAIL %s_addr got %h want %h", name, bus.addr, exp_a); end
    checks++;
    if (bus.data !== exp_d) begin errors++; $display("FAIL %s_data got %h want %h", name, bus.data, exp_d); end
    checks++;
  endtask

  task automatic test_glitch;
    int v0, e0;
    bit seen;
    v0 = n_valid; e0 = n_err; seen = 1'b0;
    @(negedge CLK_50M) bus.uart_rxd = 1'b0;
    repeat (6) @(negedge CLK_50M);
    bus.uart_rxd = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus.rx_busy === 1'b1) seen = 1'b1;
      @(negedge CLK_50M);
    end
    if (seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_seen got %b want 1", seen); end
    checks++;
    repeat (2 * BIT) @(negedge CLK_50M);
    if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_drop got %b want 0", bus.rx_busy); end
    checks++;
    if ((n_valid - v0) + (n_err - e0) !== 0) begin
      errors++; $display("FAIL glitch_pulses got %0d want 0", (n_valid - v0) + (n_err - e0));
    end
    checks++;
  endtask

  task automatic test_break;
    int e0, v0;
    e0 = n_err; v0 = n_valid;
    @(negedge CLK_50M) bus.uart_rxd = 1'b0;
    repeat (20 * BIT) @(negedge CLK_50M);
    if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL break_rearm got %b want 0", bus.rx_busy); end
    checks++;
    bus.uart_rxd = 1'b1;
    repeat (2 * BIT) @(negedge CLK_50M);
    send_str("\n", -1, BIT);
    if (n_err - e0 !== 1) begin errors++; $display("FAIL break_err_count got %0d want 1", n_err - e0); end
    checks++;
    if (n_valid - v0 !== 0) begin errors++; $display("FAIL break_valid_count got %0d want 0", n_valid - v0); end
    checks++;
  endtask

  task automatic test_reset_midline;
    send_str("AB", -1, BIT);
    @(negedge CLK_50M) rst_n = 1'b0;
    repeat (10) @(negedge CLK_50M);
    if (bus.addr !== 12'h000) begin errors++; $display("FAIL midreset_addr got %h want 000", bus.addr); end
    checks++;
    rst_n = 1'b1;
    repeat (4) @(negedge CLK_50M);
    test_line("midreset_line", "ABC: DE\n", -1, BIT, 1, 0, 12'hABC, 8'hDE);
  endtask

  initial begin
    bus.uart_rxd = 1'b1;
    repeat (5) @(negedge CLK_50M);
    rst_n = 1'b1;
    repeat (5) @(negedge CLK_50M);
    test_reset();
    test_line("basic", "1A3: 5C\n", -1, BIT, 1, 0, 12'h1A3, 8'h5C);
    test_line("lower_cr", "0ff: a0\r\n", -1, BIT, 1, 0, 12'h0FF, 8'hA0);
    test_line("bad_char", "12G: 00\n", -1, BIT, 0, 1, 12'h0FF, 8'hA0);
    test_line("after_bad", "000: 01\n", -1, BIT, 1, 0, 12'h000, 8'h01);
    test_line("parity", "7FF: 33\n", 5, BIT, 0, 1, 12'h000, 8'h01);
    test_line("after_par", "123: 45\n", -1, BIT, 1, 0, 12'h123, 8'h45);
    test_line("empty", "\n", -1, BIT, 0, 0, 12'h123, 8'h45);
    test_line("short_stop", "3C3: C3\n", -1, 12, 1, 0, 12'h3C3, 8'hC3);
    test_glitch();
    test_break();
    test_line("after_break", "5A5: A5\n", -1, BIT, 1, 0, 12'h5A5, 8'hA5);
    test_reset_midline();
    if (n_both !== 0) begin errors++; $display("FAIL valid_err_overlap got %0d want 0", n_both); end
    checks++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
